// File: rtl/klingon_digit_sequencer.sv
// Digit sequencer 0..9 feeding the Klingon seven-segment decoder (Q0=MSB).
// Ports: clk, reset(async hi), run, clear, up_dn, load, load_val -> Q0..Q3, tc, busy.
// Optional ping-pong mode when KLINGON_SEQ_BOUNCE_EN is defined.
module klingon_digit_sequencer #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned PW  = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       clear,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       Q0,
  output logic       Q1,
  output logic       Q2,
  output logic       Q3,
  output logic       tc,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    digit;
  logic          tc_r;
  logic          step;
  logic [3:0]    step_dig;
  logic          step_tc;
  logic [3:0]    ld_dig;

`ifdef KLINGON_SEQ_BOUNCE_EN
  logic dir;
  logic step_dir;
`endif

  assign step   = (state == RUN) && (presc == LAST);
  assign ld_dig = (load_val > 4'd9) ? 4'd0 : load_val;

  always_comb begin
    step_dig = digit;
    step_tc  = 1'b0;
`ifdef KLINGON_SEQ_BOUNCE_EN
    step_dir = dir;
    if (dir) begin
      if (digit >= 4'd9) begin
        step_dig = 4'd8;
        step_dir = 1'b0;
        step_tc  = 1'b1;
      end else begin
        step_dig = digit + 4'd1;
      end
    end else begin
      if (digit == 4'd0) begin
        step_dig = 4'd1;
        step_dir = 1'b1;
        step_tc  = 1'b1;
      end else begin
        step_dig = digit - 4'd1;
      end
    end
`else
    if (up_dn) begin
      if (digit >= 4'd9) begin
        step_dig = 4'd0;
        step_tc  = 1'b1;
      end else begin
        step_dig = digit + 4'd1;
      end
    end else begin
      if (digit == 4'd0) begin
        step_dig = 4'd9;
        step_tc  = 1'b1;
      end else begin
        step_dig = digit - 4'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      digit <= 4'd0;
      tc_r  <= 1'b0;
`ifdef KLINGON_SEQ_BOUNCE_EN
      dir   <= 1'b1;
`endif
    end else begin
      tc_r <= 1'b0;
      if (clear) begin
        state <= IDLE;
        presc <= '0;
        digit <= 4'd0;
`ifdef KLINGON_SEQ_BOUNCE_EN
        dir   <= up_dn;
`endif
      end else begin
        unique case (state)
          IDLE:    if (run)  state <= RUN;
          RUN:     if (!run) state <= PAUSE;
          PAUSE:   if (run)  state <= RUN;
          default: state <= IDLE;
        endcase
        // load overrides a coincident step
        if (load) begin
          presc <= '0;
          digit <= ld_dig;
        end else if (step) begin
          presc <= '0;
          digit <= step_dig;
          tc_r  <= step_tc;
`ifdef KLINGON_SEQ_BOUNCE_EN
          dir   <= step_dir;
`endif
        end else if (state == RUN) begin
          presc <= presc + 1'b1;
        end else if (state == IDLE) begin
          presc <= '0;
        end
      end
    end
  end

  assign {Q0, Q1, Q2, Q3} = digit;
  assign tc   = tc_r;
  assign busy = (state == RUN);

endmodule

// File: tb/tb_klingon_digit_sequencer.sv
// Bench for klingon_digit_sequencer: three instances (DIV=2,3,1) on shared
// stimulus, checked every cycle against a behavioural model plus literals.
module tb_klingon_digit_sequencer;

  localparam int DVS [3] = '{2, 3, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run, clear, up_dn, load;
  logic [3:0] load_val;

  logic [3:0] dq [3];
  logic       tcv [3];
  logic       bz [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic q0, q1, q2, q3, t, b;
    klingon_digit_sequencer #(.DIV(DVS[g]), .PW(2)) u_dut (
      .clk(clk), .reset(reset), .run(run), .clear(clear),
      .up_dn(up_dn), .load(load), .load_val(load_val),
      .Q0(q0), .Q1(q1), .Q2(q2), .Q3(q3), .tc(t), .busy(b)
    );
    assign dq[g]  = {q0, q1, q2, q3};
    assign tcv[g] = t;
    assign bz[g]  = b;
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: mode 0=idle 1=run 2=pause
  int m_dig [3];
  int m_st [3];
  int m_pre [3];
  int m_tc [3];
  int m_dir [3];

  function automatic void m_step(int i);
`ifdef KLINGON_SEQ_BOUNCE_EN
    if (m_dir[i] == 1) begin
      if (m_dig[i] == 9) begin
        m_dig[i] = 8; m_dir[i] = 0; m_tc[i] = 1;
      end else m_dig[i]++;
    end else begin
      if (m_dig[i] == 0) begin
        m_dig[i] = 1; m_dir[i] = 1; m_tc[i] = 1;
      end else m_dig[i]--;
    end
`else
    if (up_dn) begin
      m_tc[i] = (m_dig[i] == 9);
      m_dig[i] = (m_dig[i] + 1) % 10;
    end else begin
      m_tc[i] = (m_dig[i] == 0);
      m_dig[i] = (m_dig[i] + 9) % 10;
    end
`endif
  endfunction

  function automatic void m_edge(int i);
    int old;
    if (reset) begin
      m_dig[i] = 0; m_st[i] = 0; m_pre[i] = 0;
      m_tc[i] = 0; m_dir[i] = 1;
      return;
    end
    m_tc[i] = 0;
    if (clear) begin
      m_dig[i] = 0; m_st[i] = 0; m_pre[i] = 0;
      m_dir[i] = int'(up_dn);
      return;
    end
    old = m_st[i];
    if (load) begin
      m_pre[i] = 0;
      m_dig[i] = (load_val <= 9) ? int'(load_val) : 0;
    end else if (old == 1 && m_pre[i] == DVS[i] - 1) begin
      m_pre[i] = 0;
      m_step(i);
    end else if (old == 1) begin
      m_pre[i]++;
    end else if (old == 0) begin
      m_pre[i] = 0;
    end
    if (old == 0 && run) m_st[i] = 1;
    else if (old == 1 && !run) m_st[i] = 2;
    else if (old == 2 && run) m_st[i] = 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) m_edge(i);
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("digit%0d", i), int'(dq[i]), m_dig[i]);
      chk($sformatf("tc%0d", i), int'(tcv[i]), m_tc[i]);
      chk($sformatf("busy%0d", i), int'(bz[i]), int'(m_st[i] == 1));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  int tcn;

  initial begin
    run = 0; clear = 0; up_dn = 1; load = 0; load_val = 0;
    cyc(2);
    chk("rst_digit", int'(dq[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_tc", int'(tcv[0]), 0);
    reset = 0;

    // count up, DIV=2
    run = 1; up_dn = 1; tcn = 0;
    for (int i = 1; i <= 21; i++) begin
      cyc(1);
      tcn += int'(tcv[0]);
    end
`ifdef KLINGON_SEQ_BOUNCE_EN
    chk("up_digit", int'(dq[0]), 8);
`else
    chk("up_digit", int'(dq[0]), 0);
`endif
    chk("up_tc", int'(tcv[0]), 1);
    chk("up_tccount", tcn, 1);

    // count down from 0
    clear = 1; run = 0; up_dn = 0;
    cyc(1);
    clear = 0; run = 1;
    cyc(3);
`ifdef KLINGON_SEQ_BOUNCE_EN
    chk("dn_first", int'(dq[0]), 1);
`else
    chk("dn_first", int'(dq[0]), 9);
`endif
    chk("dn_first_tc", int'(tcv[0]), 1);
    cyc(18);
`ifdef KLINGON_SEQ_BOUNCE_EN
    chk("dn_last", int'(dq[0]), 8);
    chk("dn_last_tc", int'(tcv[0]), 1);
`else
    chk("dn_last", int'(dq[0]), 0);
    chk("dn_last_tc", int'(tcv[0]), 0);
`endif

    // pause with DIV=3
    clear = 1; run = 0; up_dn = 1;
    cyc(1);
    clear = 0; run = 1;
    cyc(2);
    run = 0;
    cyc(1);
    chk("pause_busy", int'(bz[1]), 0);
    cyc(4);
    chk("pause_digit", int'(dq[1]), 0);
    chk("pause_busy2", int'(bz[1]), 0);
    run = 1;
    cyc(1);
    chk("resume_busy", int'(bz[1]), 1);
    chk("resume_digit", int'(dq[1]), 0);
    cyc(1);
    chk("resume_step", int'(dq[1]), 1);

    // parallel load
    load = 1; load_val = 4'd7;
    cyc(1);
    for (int i = 0; i < 3; i++)
      chk($sformatf("load7_%0d", i), int'(dq[i]), 7);
    load_val = 4'd12;
    cyc(1);
    chk("load12", int'(dq[0]), 0);
    load_val = 4'd9;
    cyc(2);
    chk("load_vs_step", int'(dq[2]), 9);
    chk("load_vs_step_tc", int'(tcv[2]), 0);
    load = 0;

    // async reset mid-prescale
    clear = 1; run = 0;
    cyc(1);
    clear = 0; load = 1; load_val = 4'd5;
    cyc(1);
    load = 0; run = 1;
    cyc(2);
    chk("pre_rst_digit", int'(dq[1]), 5);
    #2 reset = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_digit%0d", i), int'(dq[i]), 0);
      chk($sformatf("arst_busy%0d", i), int'(bz[i]), 0);
      chk($sformatf("arst_tc%0d", i), int'(tcv[i]), 0);
    end
    cyc(1);
    run = 0; reset = 0;
    cyc(2);
    chk("post_rst_idle", int'(bz[0]), 0);

    // clear beats load
    run = 1;
    cyc(5);
    clear = 1; load = 1; load_val = 4'd6;
    cyc(1);
    chk("clr_load_digit", int'(dq[0]), 0);
    chk("clr_load_busy", int'(bz[0]), 0);
    clear = 0; load = 0;

    // mixed directed pattern
    for (int i = 0; i < 60; i++) begin
      up_dn = ((i % 7) < 3);
      run = ((i % 11) != 10);
      load = ((i % 13) == 5);
      load_val = 4'(i % 16);
      cyc(1);
    end
    load = 0;

`ifdef KLINGON_SEQ_BOUNCE_EN
    // ping-pong with DIV=1
    clear = 1; up_dn = 1; run = 0;
    cyc(1);
    clear = 0; run = 1; up_dn = 0; tcn = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      tcn += int'(tcv[2]);
      if (i == 11) chk("bnc_top", int'(dq[2]), 8);
    end
    chk("bnc_bottom", int'(dq[2]), 1);
    chk("bnc_tc", int'(tcv[2]), 1);
    chk("bnc_tccount", tcn, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
